// File: rtl/signed_addsub_pkg.sv
// Shared types and constants for the signed add/sub block with overflow
// classification.
package signed_addsub_pkg;

    // Overflow classification of one add/sub beat.
    typedef enum logic [1:0] {
        OVF_NONE = 2'd0,
        OVF_POS  = 2'd1,
        OVF_NEG  = 2'd2
    } ovf_kind_e;

    // Largest positive two's-complement value for a w-bit word (0111..1).
    // Returned in 64 bits so callers can cast down to their own width.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value for a w-bit word (1000..0),
    // as a w-bit pattern zero-extended to 64 bits.
    function automatic logic [63:0] min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/signed_ovf_detect.sv
// Combinational signed add/sub with overflow classification.
// Both operands are sign-extended by one bit, so the top two bits of the
// extended sum disagree exactly when the true result does not fit in WIDTH
// bits. That holds for subtraction of the most negative value as well,
// which a plain operand-sign rule for addition would get wrong.
module signed_ovf_detect
    import signed_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] wrap_sum,
    output ovf_kind_e        kind
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] full;

    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = {b[WIDTH-1], b};

    // Extended-width add or subtract, then classify from the top two bits.
    always_comb begin
        full = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        kind = OVF_NONE;
        if (!full[WIDTH] && full[WIDTH-1]) begin
            kind = OVF_POS;
        end else if (full[WIDTH] && !full[WIDTH-1]) begin
            kind = OVF_NEG;
        end
    end

    assign wrap_sum = full[WIDTH-1:0];

endmodule

// File: rtl/signed_addsub_ovf.sv
// Registered signed adder/subtractor with overflow flags, optional
// saturation, a sticky overflow flag and a saturating overflow counter.
// A single output register gives one-cycle latency and full throughput
// under a valid/ready handshake on both sides.
module signed_addsub_ovf
    import signed_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             ovf_pos,
    output logic             ovf_neg,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr
);

    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Arithmetic on the incoming beat
    logic [WIDTH-1:0] wrap_sum;
    ovf_kind_e        kind;

    signed_ovf_detect #(
        .WIDTH (WIDTH)
    ) u_detect (
        .a        (a),
        .b        (b),
        .sub      (sub),
        .wrap_sum (wrap_sum),
        .kind     (kind)
    );

    // Output register (out_valid_q is the only occupancy state) and status
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             valid_q,     valid_d;
    logic             ovf_pos_q,   ovf_pos_d;
    logic             ovf_neg_q,   ovf_neg_d;
    logic             sticky_q,    sticky_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             accept;
    logic             beat_ovf;
    logic [WIDTH-1:0] sel_result;

    // A new beat may enter whenever the register is empty or being drained.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign beat_ovf = (kind != OVF_NONE);

    // Saturation mux: clamp only when saturation is requested and the
    // beat actually overflowed; otherwise pass the wrapped sum.
    always_comb begin
        sel_result = wrap_sum;
        if (sat_en) begin
            case (kind)
                OVF_POS: sel_result = MAX_POS;
                OVF_NEG: sel_result = MIN_NEG;
                default: sel_result = wrap_sum;
            endcase
        end
    end

    // Next-state for the data register: load on accept, otherwise hold.
    // Occupancy drops only when the consumer takes the beat and nothing
    // new arrives in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        valid_d     = valid_q;
        ovf_pos_d   = ovf_pos_q;
        ovf_neg_d   = ovf_neg_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = sel_result;
            valid_d     = ~beat_ovf;
            ovf_pos_d   = (kind == OVF_POS);
            ovf_neg_d   = (kind == OVF_NEG);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Next-state for status: clear first, then let an overflowed accept
    // in the same cycle count, so clr never hides a coincident event.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (accept && beat_ovf) begin
            sticky_d = 1'b1;
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    // State registers; reset discards any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b1;
            ovf_pos_q   <= 1'b0;
            ovf_neg_q   <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            ovf_pos_q   <= ovf_pos_d;
            ovf_neg_q   <= ovf_neg_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign valid      = valid_q;
    assign ovf_pos    = ovf_pos_q;
    assign ovf_neg    = ovf_neg_q;
    assign sticky_ovf = sticky_q;
    assign ovf_count  = cnt_q;

endmodule
